multiplier_pipe: RTL and testbench

Parametrised, pipelined integer multiplier for the single-cycle/pipelined RISC-V datapath, executing all four RV32M/RV64M multiply operations (MUL, MULH, MULHSU, MULHU) selected per transaction. It generalises the fixed 32-bit, high/low-select multiplier with:

- configurable operand width and pipeline depth;
- signed, unsigned and mixed-sign products;
- a valid/ready handshake with full back-pressure;
- a synchronous flush.

It sits beside the ALU in the execute stage. Results are returned in issue order.

---
 rtl/multiplier_pipe.sv | 228 ++++++++++++++++++++++
 tb/tb_multiplier_pipe.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_pipe.sv
// -----------------------------------------------------------------------------
// multiplier_pipe
//
// Pipelined integer multiplier for the execute stage. It runs the four RV32M /
// RV64M multiply operations (MUL, MULH, MULHSU, MULHU), chosen per request.
// Results come back in issue order, each with the caller's tag.
//
// How it works:
//   - The operands are extended to XLEN+1 bits. A signed product truncated to
//     2*XLEN bits covers every sign mode.
//   - The XLEN+1 partial-product rows are reduced with 3:2 carry-save levels.
//   - The rows are spread as evenly as possible across the STAGES registers.
//     The first share is folded in front of stage 0, at accept time.
//   - The last register holds a (sum, carry) pair. One carry-propagate add
//     and the high/low select are combinational from that register.
//   - Handshake: every stage moves together when the output slot is free or
//     is being consumed. Bubbles move along with real work and are never
//     squeezed out.
//
// Parameters:
//   XLEN   - operand/result width (32 or 64)
//   STAGES - pipeline registers between accept and result (1..4)
//   TAGW   - width of the caller tag
//
// Ports:
//   clk       - clock, rising edge
//   reset     - synchronous active-low reset
//   flush     - synchronous kill of all in-flight operations
//   in_valid  - request valid
//   in_ready  - request accepted when in_valid && in_ready
//   in_1      - multiplicand (rs1)
//   in_2      - multiplier (rs2)
//   op        - 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   in_tag    - caller tag
//   out_valid - result valid
//   out_ready - consumer ready
//   out       - result (0 while out_valid is low)
//   out_tag   - tag of the result (0 while out_valid is low)
//   busy      - any stage holds a valid operation
// -----------------------------------------------------------------------------
module multiplier_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 3,
  parameter int TAGW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_1,
  input  logic [XLEN-1:0] in_2,
  input  logic [1:0]      op,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out,
  output logic [TAGW-1:0] out_tag,
  output logic            busy
);

  // Product width after truncation, and the number of partial-product rows.
  // Rows 0..XLEN-1 weigh +2^i. Row XLEN is the sign row of the multiplier
  // and weighs -2^XLEN.
  localparam int PW   = 2 * XLEN;
  localparam int ROWS = XLEN + 1;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_e;

  // One pipeline slot.
  // - The operands travel along so each stage can form the rows it owns.
  // - The running value of the product is always sum + carry (mod 2^PW).
  typedef struct packed {
    logic [1:0]      op;
    logic [TAGW-1:0] tag;
    logic [PW-1:0]   mcand;   // multiplicand, already extended to PW bits
    logic [XLEN:0]   mplier;  // multiplier, extended to XLEN+1 bits
    logic [PW-1:0]   sum;
    logic [PW-1:0]   carry;
  } stage_t;

  // First row that stage k reduces. Stage k owns rows [row_lo(k), row_lo(k+1)).
  // This gives an even split, with any extra rows going to the later stages.
  function automatic int row_lo(input int k);
    return (k * ROWS) / STAGES;
  endfunction

  // Fold rows [lo, hi) into the carry-save pair, one 3:2 level per row.
  //
  // The sign row should add -(mcand << XLEN). That equals
  // ~(mcand << XLEN) + 1. Only the inverted term is added here. The +1 was
  // already placed in bit 0 of the initial carry, so no adder is needed.
  function automatic stage_t reduce_rows(input stage_t s, input int lo, input int hi);
    stage_t        r;
    logic [PW-1:0] pp;
    logic [PW-1:0] t_sum;
    logic [PW-1:0] t_carry;
    r = s;
    for (int i = 0; i < ROWS; i++) begin
      pp = '0;
      if (i >= lo && i < hi) begin
        if (i < XLEN) begin
          pp = s.mplier[i] ? (s.mcand << i) : '0;
        end else begin
          pp = s.mplier[XLEN] ? ~(s.mcand << XLEN) : '0;
        end
        t_sum   = r.sum ^ r.carry ^ pp;
        t_carry = ((r.sum & r.carry) | (r.sum & pp) | (r.carry & pp)) << 1;
        r.sum   = t_sum;
        r.carry = t_carry;
      end
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Operand extension at accept
  // ---------------------------------------------------------------------------
  logic   sext_1;
  logic   sext_2;
  stage_t head;

  // NOTE: every signal written in an always_comb gets a default at the top of
  // the block, so no path can leave it unassigned and infer a latch.
  always_comb begin
    sext_1 = 1'b0;
    sext_2 = 1'b0;
    case (op_e'(op))
      OP_MULH: begin
        sext_1 = 1'b1;
        sext_2 = 1'b1;
      end
      OP_MULHSU: begin
        sext_1 = 1'b1;
        sext_2 = 1'b0;
      end
      OP_MUL, OP_MULHU: begin
        sext_1 = 1'b0;
        sext_2 = 1'b0;
      end
    endcase
  end

  always_comb begin
    head        = '0;
    head.op     = op;
    head.tag    = in_tag;
    head.mcand  = sext_1 ? {{XLEN{in_1[XLEN-1]}}, in_1} : {{XLEN{1'b0}}, in_1};
    head.mplier = {sext_2 & in_2[XLEN-1], in_2};
    head.sum    = '0;
    // Pre-load the +1 that completes the negation of the sign row.
    head.carry  = {{(PW-1){1'b0}}, head.mplier[XLEN]};
  end

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] valid_q;
  stage_t            data_d [STAGES];
  stage_t            data_q [STAGES];
  logic              advance;

  assign out_valid = valid_q[STAGES-1];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign busy      = |valid_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (advance) begin
      valid_d[0] = in_valid;
      data_d[0]  = reduce_rows(head, row_lo(0), row_lo(1));
      for (int k = 1; k < STAGES; k++) begin
        valid_d[k] = valid_q[k-1];
        data_d[k]  = reduce_rows(data_q[k-1], row_lo(k), row_lo(k+1));
      end
    end
    // A flush also drops any request presented in the same cycle.
    if (flush) begin
      valid_d = '0;
    end
  end

  // NOTE: state registers are written with non-blocking assignments only.
  // That way every flop samples the values from before the edge, whatever
  // order the simulator runs the processes in.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // NOTE: the wide data registers are deliberately left out of reset. The
  // valid bits alone decide whether a slot means anything, and the output is
  // masked by valid.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  // ---------------------------------------------------------------------------
  // Final carry-propagate add and high/low select
  // ---------------------------------------------------------------------------
  logic [PW-1:0] product;

  always_comb begin
    product = data_q[STAGES-1].sum + data_q[STAGES-1].carry;
    out     = '0;
    out_tag = '0;
    if (out_valid) begin
      out_tag = data_q[STAGES-1].tag;
      if (op_e'(data_q[STAGES-1].op) == OP_MUL) begin
        out = product[XLEN-1:0];
      end else begin
        out = product[PW-1:XLEN];
      end
    end
  end

endmodule

// File: tb/tb_multiplier_pipe.sv
// -----------------------------------------------------------------------------
// tb_multiplier_pipe
//
// Two instances are simulated side by side:
//   - u_dut32: XLEN=32, STAGES=3
//   - u_dut64: XLEN=64, STAGES=2
//
// A behavioural model runs for each instance.
//   - Expected results come from plain wide signed arithmetic.
//   - Timing is tracked as a list of in-flight operations, each with the
//     number of pipeline moves it has made.
//   - The head operation is visible once it has made STAGES moves.
//
// On every falling edge a compare process checks out_valid, out, out_tag,
// busy and in_ready against the model.
// -----------------------------------------------------------------------------
module tb_multiplier_pipe;

  localparam int TAGW = 5;
  localparam int ST32 = 3;
  localparam int ST64 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic            flush0, vin0, irdy0, ovld0, ordy0, busy0;
  logic [31:0]     a0, b0, out0;
  logic [1:0]      op0;
  logic [TAGW-1:0] tag0, otag0;

  logic            flush1, vin1, irdy1, ovld1, ordy1, busy1;
  logic [63:0]     a1, b1, out1;
  logic [1:0]      op1;
  logic [TAGW-1:0] tag1, otag1;

  multiplier_pipe #(.XLEN(32), .STAGES(ST32), .TAGW(TAGW)) u_dut32 (
    .clk(clk), .reset(rst_n), .flush(flush0),
    .in_valid(vin0), .in_ready(irdy0), .in_1(a0), .in_2(b0), .op(op0), .in_tag(tag0),
    .out_valid(ovld0), .out_ready(ordy0), .out(out0), .out_tag(otag0), .busy(busy0)
  );

  multiplier_pipe #(.XLEN(64), .STAGES(ST64), .TAGW(TAGW)) u_dut64 (
    .clk(clk), .reset(rst_n), .flush(flush1),
    .in_valid(vin1), .in_ready(irdy1), .in_1(a1), .in_2(b1), .op(op1), .in_tag(tag1),
    .out_valid(ovld1), .out_ready(ordy1), .out(out1), .out_tag(otag1), .busy(busy1)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result.
  // - Extend the operands to 130 bits as the operation dictates.
  // - Multiply them as signed numbers.
  // - Pick the low or high XLEN bits of the 2*XLEN-bit product.
  function automatic logic [63:0] ref_mul(input int xl, input logic [1:0] o,
                                          input logic [63:0] a, input logic [63:0] b);
    logic signed [129:0] ea, eb;
    logic [129:0]        p;
    logic                sa, sb;
    sa = (o == 2'b01) || (o == 2'b10);
    sb = (o == 2'b01);
    if (xl == 32) begin
      ea = sa ? {{98{a[31]}}, a[31:0]} : {98'b0, a[31:0]};
      eb = sb ? {{98{b[31]}}, b[31:0]} : {98'b0, b[31:0]};
    end else begin
      ea = sa ? {{66{a[63]}}, a} : {66'b0, a};
      eb = sb ? {{66{b[63]}}, b} : {66'b0, b};
    end
    p = ea * eb;
    if (xl == 32) return (o == 2'b00) ? {32'b0, p[31:0]} : {32'b0, p[63:32]};
    else          return (o == 2'b00) ? p[63:0] : p[127:64];
  endfunction

  // ---------------------------------------------------------------------------
  // Per-instance model: in-flight operations, oldest first
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [63:0]     val;
    logic [TAGW-1:0] tag;
    int              age;
  } exp_t;

  exp_t mq [2][8];
  int   mn [2];

  task automatic model_step(input int d);
    int              st, xl;
    logic            vld, rdy, ir, bs, fl, iv, ev, adv;
    logic [63:0]     o, xa, xb, eo;
    logic [TAGW-1:0] ot, xt, et;
    logic [1:0]      xop;
    if (d == 0) begin
      st = ST32; xl = 32; vld = ovld0; rdy = ordy0; ir = irdy0; bs = busy0;
      o = {32'b0, out0}; ot = otag0; fl = flush0; iv = vin0;
      xa = {32'b0, a0}; xb = {32'b0, b0}; xop = op0; xt = tag0;
    end else begin
      st = ST64; xl = 64; vld = ovld1; rdy = ordy1; ir = irdy1; bs = busy1;
      o = out1; ot = otag1; fl = flush1; iv = vin1;
      xa = a1; xb = b1; xop = op1; xt = tag1;
    end
    ev = (mn[d] > 0) && (mq[d][0].age == st);
    eo = ev ? mq[d][0].val : 64'd0;
    et = ev ? mq[d][0].tag : '0;
    if (chk_en) begin
      check($sformatf("dut%0d out_valid", d), {63'b0, vld}, {63'b0, ev});
      check($sformatf("dut%0d busy", d), {63'b0, bs}, {63'b0, (mn[d] > 0)});
      check($sformatf("dut%0d in_ready", d), {63'b0, ir}, {63'b0, (!ev || rdy)});
      check($sformatf("dut%0d out", d), o, eo);
      check($sformatf("dut%0d out_tag", d), {59'b0, ot}, {59'b0, et});
    end
    adv = !ev || rdy;
    if (ev && rdy) begin
      for (int i = 0; i < mn[d] - 1; i++) mq[d][i] = mq[d][i+1];
      mn[d]--;
    end
    if (!rst_n || fl) begin
      mn[d] = 0;
    end else if (adv) begin
      for (int i = 0; i < mn[d]; i++) mq[d][i].age++;
      if (iv) begin
        if (mn[d] < 8) begin
          mq[d][mn[d]].val = ref_mul(xl, xop, xa, xb);
          mq[d][mn[d]].tag = xt;
          mq[d][mn[d]].age = 1;
          mn[d]++;
        end else begin
          check($sformatf("dut%0d model depth", d), 64'(mn[d]), 64'(st));
        end
      end
    end
  endtask

  always @(negedge clk) begin
    model_step(0);
    model_step(1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic drive(input int d, input logic v, input logic [1:0] o,
                       input logic [63:0] a, input logic [63:0] b, input logic [TAGW-1:0] t);
    if (d == 0) begin
      vin0 = v; op0 = o; a0 = a[31:0]; b0 = b[31:0]; tag0 = t;
    end else begin
      vin1 = v; op1 = o; a1 = a; b1 = b; tag1 = t;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation into an idle pipe with out_ready high, then check
  // the result, the tag and the latency in edges counted from the accept edge.
  task automatic run_one(input int d, input logic [1:0] o, input logic [63:0] a,
                         input logic [63:0] b, input logic [TAGW-1:0] t,
                         input logic [63:0] exp, input string name);
    int   cnt;
    logic v;
    if (d == 0) ordy0 = 1'b1; else ordy1 = 1'b1;
    drive(d, 1'b1, o, a, b, t);
    tick();
    drive(d, 1'b0, 2'b00, 64'd0, 64'd0, '0);
    cnt = 1;
    v = (d == 0) ? ovld0 : ovld1;
    while (!v && cnt < 20) begin
      tick();
      cnt++;
      v = (d == 0) ? ovld0 : ovld1;
    end
    check({name, " latency"}, 64'(cnt), 64'((d == 0) ? ST32 : ST64));
    check({name, " value"}, (d == 0) ? {32'b0, out0} : out1, exp);
    check({name, " tag"}, {59'b0, (d == 0) ? otag0 : otag1}, {59'b0, t});
  endtask

  // Let the pipe empty with a random consumer. The consumer becomes always
  // ready after a while, so the loop is bounded.
  task automatic drain(input int d);
    int   n;
    logic idle;
    n = 0;
    idle = 1'b0;
    while (!idle && n < 100) begin
      if (d == 0) ordy0 = (n > 20) ? 1'b1 : 1'($urandom_range(0, 1));
      else        ordy1 = (n > 20) ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
      n++;
      idle = (d == 0) ? (!ovld0 && !busy0) : (!ovld1 && !busy1);
    end
    check($sformatf("dut%0d drained", d), {63'b0, idle}, 64'd1);
    if (d == 0) ordy0 = 1'b1; else ordy1 = 1'b1;
  endtask

  function automatic logic [63:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return 64'd1;
      2:       return 64'hFFFF_FFFF_FFFF_FFFF;
      3:       return 64'h8000_0000_0000_0000;
      4:       return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Keep offering random operations until n have been accepted. The
  // consumer is ready about pct_ready percent of the time.
  task automatic stream(input int d, input int n, input int pct_ready);
    int          sent, guard;
    logic        acc;
    logic [63:0] ra, rb;
    logic [1:0]  ro;
    sent = 0;
    guard = 0;
    ra = rnd_operand(); rb = rnd_operand(); ro = 2'($urandom_range(0, 3));
    while (sent < n && guard < 20 * n + 100) begin
      if (d == 0) ordy0 = ($urandom_range(0, 99) < pct_ready);
      else        ordy1 = ($urandom_range(0, 99) < pct_ready);
      drive(d, 1'b1, ro, ra, rb, TAGW'(sent));
      #1;
      acc = (d == 0) ? irdy0 : irdy1;
      tick();
      guard++;
      if (acc) begin
        sent++;
        ra = rnd_operand(); rb = rnd_operand(); ro = 2'($urandom_range(0, 3));
      end
    end
    drive(d, 1'b0, 2'b00, 64'd0, 64'd0, '0);
    check($sformatf("dut%0d stream issued", d), 64'(sent), 64'(n));
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    mn[0] = 0;
    mn[1] = 0;
    rst_n = 1'b0;
    flush0 = 1'b0; flush1 = 1'b0;
    ordy0 = 1'b1; ordy1 = 1'b1;
    drive(0, 1'b0, 2'b00, 64'd0, 64'd0, '0);
    drive(1, 1'b0, 2'b00, 64'd0, 64'd0, '0);
    tick();
    tick();
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick();

    // Reset state, checked explicitly.
    check("reset out_valid", {63'b0, ovld0}, 64'd0);
    check("reset busy", {63'b0, busy0}, 64'd0);
    check("reset in_ready", {63'b0, irdy0}, 64'd1);
    check("reset out", {32'b0, out0}, 64'd0);

    // Hand-computed values that pin the reference model itself.
    check("model MULH -1*2", ref_mul(32, 2'b01, 64'hFFFF_FFFF, 64'd2), 64'hFFFF_FFFF);
    check("model MULHU -1*2", ref_mul(32, 2'b11, 64'hFFFF_FFFF, 64'd2), 64'h1);
    check("model MULH min*min", ref_mul(32, 2'b01, 64'h8000_0000, 64'h8000_0000), 64'h4000_0000);
    check("model MULH64 min*-1", ref_mul(64, 2'b01, 64'h8000_0000_0000_0000,
                                         64'hFFFF_FFFF_FFFF_FFFF), 64'h0);
    check("model MUL64 min*-1", ref_mul(64, 2'b00, 64'h8000_0000_0000_0000,
                                        64'hFFFF_FFFF_FFFF_FFFF), 64'h8000_0000_0000_0000);

    // Directed operations against literal results.
    run_one(0, 2'b00, 64'd7, 64'd6, 5'd3, 64'd42, "MUL 7x6");
    run_one(0, 2'b01, 64'hFFFF_FFFF, 64'd2, 5'd4, 64'hFFFF_FFFF, "MULH -1x2");
    run_one(0, 2'b10, 64'hFFFF_FFFF, 64'd2, 5'd5, 64'hFFFF_FFFF, "MULHSU -1x2");
    run_one(0, 2'b11, 64'hFFFF_FFFF, 64'd2, 5'd6, 64'h0000_0001, "MULHU -1x2");
    run_one(0, 2'b00, 64'hFFFF_FFFF, 64'd2, 5'd7, 64'hFFFF_FFFE, "MUL -1x2");
    run_one(0, 2'b01, 64'h8000_0000, 64'h8000_0000, 5'd8, 64'h4000_0000, "MULH min*min");
    run_one(0, 2'b00, 64'h8000_0000, 64'h8000_0000, 5'd9, 64'h0, "MUL min*min");
    run_one(0, 2'b11, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd10, 64'hFFFF_FFFE, "MULHU max*max");
    tick();

    // Back-pressure: 6 operations with a random consumer.
    stream(0, 6, 50);
    drain(0);

    // Flush. Two operations are in flight and a third is presented together
    // with flush while in_ready is high; all three must disappear.
    ordy0 = 1'b1;
    drive(0, 1'b1, 2'b00, 64'd11, 64'd12, 5'd20);
    tick();
    drive(0, 1'b1, 2'b11, 64'd13, 64'd14, 5'd21);
    tick();
    drive(0, 1'b1, 2'b01, 64'd15, 64'd16, 5'd22);
    flush0 = 1'b1;
    #1;
    check("flush-cycle in_ready", {63'b0, irdy0}, 64'd1);
    tick();
    flush0 = 1'b0;
    drive(0, 1'b0, 2'b00, 64'd0, 64'd0, '0);
    check("flush busy", {63'b0, busy0}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("flush out_valid +%0d", i), {63'b0, ovld0}, 64'd0);
      tick();
    end

    // Reset in the middle of operations, with a request presented as well.
    drive(0, 1'b1, 2'b00, 64'd3, 64'd5, 5'd23);
    tick();
    drive(0, 1'b1, 2'b10, 64'd7, 64'd9, 5'd24);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(0, 1'b0, 2'b00, 64'd0, 64'd0, '0);
    check("post-reset busy", {63'b0, busy0}, 64'd0);
    check("post-reset out", {32'b0, out0}, 64'd0);
    check("post-reset in_ready", {63'b0, irdy0}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("post-reset out_valid +%0d", i), {63'b0, ovld0}, 64'd0);
      tick();
    end

    // XLEN=64: a directed corner case, then a random regression.
    run_one(1, 2'b01, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 64'h0,
            "MULH64 min*-1");
    run_one(1, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2,
            64'hFFFF_FFFF_FFFF_FFFE, "MULHU64 max*max");
    stream(1, 1000, 75);
    drain(1);

    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
